// File: rtl/bullet_ctrl.sv
// bullet_ctrl: single in-flight bullet for the player tank (arm on fire edge, spawn, fly, retire).
// Optional post-retire cooldown is enabled by defining BULLET_COOLDOWN_EN.
module bullet_ctrl #(
  parameter int BULLET_SIZE    = 4,
  parameter int SPEED          = 4,
  parameter int TANK_SIZE      = 32,
  parameter int COOLDOWN_TICKS = 30
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       fire,
  input  logic [1:0] dir,
  input  logic [9:0] x_tank_l,
  input  logic [9:0] y_tank_t,
  input  logic       hit,
  output logic [9:0] x_bullet_l,
  output logic [9:0] x_bullet_r,
  output logic [9:0] y_bullet_t,
  output logic [9:0] y_bullet_b,
  output logic       bullet_active,
  output logic       bullet_done
);

  localparam logic [10:0] ARENA_LO   = 11'd32;
  localparam logic [10:0] ARENA_X_HI = 11'd607;
  localparam logic [10:0] ARENA_Y_HI = 11'd447;
  localparam logic [10:0] BSZ        = 11'(BULLET_SIZE);
  localparam logic [10:0] BLAST      = 11'(BULLET_SIZE - 1);
  localparam logic [10:0] TSZ        = 11'(TANK_SIZE);
  localparam logic [10:0] SPD        = 11'(SPEED);
  localparam logic [10:0] CTR        = 11'(TANK_SIZE / 2 - BULLET_SIZE / 2);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

`ifdef BULLET_COOLDOWN_EN
  typedef enum logic [1:0] {IDLE, ARMED, FLY, COOLDOWN} state_t;
  localparam state_t RETIRE_ST = COOLDOWN;
  localparam int CNT_W = $clog2(COOLDOWN_TICKS + 2);
  logic [CNT_W-1:0] cool_cnt;
`else
  typedef enum logic [1:0] {IDLE, ARMED, FLY} state_t;
  localparam state_t RETIRE_ST = IDLE;
`endif

  state_t      state, state_nxt;
  logic        fire_q, fire_edge;
  logic [1:0]  dir_q;
  logic [10:0] cur_l, cur_t, spawn_l, spawn_t, step_l, step_t, pos_l, pos_t;
  logic        do_load, do_step, do_retire;

  // Wrapped (negative) 11-bit results land above the high bounds, so they read as outside.
  function automatic logic in_arena(input logic [10:0] l, input logic [10:0] t);
    return (l >= ARENA_LO) && (l + BLAST <= ARENA_X_HI) &&
           (t >= ARENA_LO) && (t + BLAST <= ARENA_Y_HI);
  endfunction

  // fire_q tracks the button even through reset, so a button held across reset is not a new press.
  always_ff @(posedge clk_50MHz) fire_q <= fire;
  assign fire_edge = fire & ~fire_q;

  assign cur_l = {1'b0, x_bullet_l};
  assign cur_t = {1'b0, y_bullet_t};

  always_comb begin
    spawn_l = {1'b0, x_tank_l} + CTR;
    spawn_t = {1'b0, y_tank_t} - BSZ;
    case (dir)
      DIR_DOWN:  spawn_t = {1'b0, y_tank_t} + TSZ;
      DIR_LEFT:  begin
        spawn_l = {1'b0, x_tank_l} - BSZ;
        spawn_t = {1'b0, y_tank_t} + CTR;
      end
      DIR_RIGHT: begin
        spawn_l = {1'b0, x_tank_l} + TSZ;
        spawn_t = {1'b0, y_tank_t} + CTR;
      end
      default: ;
    endcase
  end

  always_comb begin
    step_l = cur_l;
    step_t = cur_t;
    case (dir_q)
      DIR_UP:    step_t = cur_t - SPD;
      DIR_DOWN:  step_t = cur_t + SPD;
      DIR_LEFT:  step_l = cur_l - SPD;
      DIR_RIGHT: step_l = cur_l + SPD;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_step   = 1'b0;
    do_retire = 1'b0;
    case (state)
      IDLE:  if (fire_edge) state_nxt = ARMED;
      ARMED: if (refresh_tick) begin
        if (in_arena(spawn_l, spawn_t)) begin
          state_nxt = FLY;
          do_load   = 1'b1;
        end else begin
          state_nxt = RETIRE_ST;
          do_retire = 1'b1;
        end
      end
      FLY: if (refresh_tick) begin
        if (hit || !in_arena(step_l, step_t)) begin
          state_nxt = RETIRE_ST;
          do_retire = 1'b1;
        end else begin
          do_step = 1'b1;
        end
      end
`ifdef BULLET_COOLDOWN_EN
      COOLDOWN: if (cool_cnt == '0 || (refresh_tick && cool_cnt == CNT_W'(1))) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign pos_l = do_load ? spawn_l : step_l;
  assign pos_t = do_load ? spawn_t : step_t;

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      dir_q         <= DIR_UP;
      x_bullet_l    <= '0;
      x_bullet_r    <= '0;
      y_bullet_t    <= '0;
      y_bullet_b    <= '0;
      bullet_active <= 1'b0;
      bullet_done   <= 1'b0;
    end else begin
      state         <= state_nxt;
      bullet_done   <= do_retire;
      bullet_active <= (state_nxt == FLY);
      if (do_load) dir_q <= dir;
      if (do_retire) begin
        x_bullet_l <= '0;
        x_bullet_r <= '0;
        y_bullet_t <= '0;
        y_bullet_b <= '0;
      end else if (do_load || do_step) begin
        x_bullet_l <= pos_l[9:0];
        x_bullet_r <= 10'(pos_l + BLAST);
        y_bullet_t <= pos_t[9:0];
        y_bullet_b <= 10'(pos_t + BLAST);
      end
    end
  end

`ifdef BULLET_COOLDOWN_EN
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      cool_cnt <= '0;
    end else if (do_retire) begin
      cool_cnt <= CNT_W'(COOLDOWN_TICKS);
    end else if (state == COOLDOWN && refresh_tick && cool_cnt != '0) begin
      cool_cnt <= cool_cnt - CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bullet_ctrl.sv
// Directed testbench for bullet_ctrl: spawn, flight, wall/hit retire, blocked spawn, re-arm, async reset.
module tb_bullet_ctrl;
  logic       clk_50MHz = 1'b0;
  logic       reset = 1'b1, refresh_tick = 1'b0, fire = 1'b0, hit = 1'b0;
  logic [1:0] dir = 2'd0;
  logic [9:0] x_tank_l = '0, y_tank_t = '0;
  logic [9:0] x_bullet_l, x_bullet_r, y_bullet_t, y_bullet_b;
  logic       bullet_active, bullet_done;
  logic [39:0] box;
  int checks = 0;
  int errors = 0;

  always #10 clk_50MHz = ~clk_50MHz;

  bullet_ctrl dut (
    .clk_50MHz(clk_50MHz), .reset(reset), .refresh_tick(refresh_tick), .fire(fire),
    .dir(dir), .x_tank_l(x_tank_l), .y_tank_t(y_tank_t), .hit(hit),
    .x_bullet_l(x_bullet_l), .x_bullet_r(x_bullet_r), .y_bullet_t(y_bullet_t),
    .y_bullet_b(y_bullet_b), .bullet_active(bullet_active), .bullet_done(bullet_done)
  );

  assign box = {x_bullet_l, x_bullet_r, y_bullet_t, y_bullet_b};

  task automatic step();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic tick();
    refresh_tick = 1'b1;
    step();
    refresh_tick = 1'b0;
  endtask

  task automatic fire_pulse();
    fire = 1'b1;
    step();
    fire = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    step();
    step();
    checks++; if (box !== 40'd0) begin errors++;
      $display("FAIL reset_box: got l=%0d r=%0d t=%0d b=%0d expected all 0", x_bullet_l, x_bullet_r, y_bullet_t, y_bullet_b); end
    checks++; if (bullet_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", bullet_active); end
    checks++; if (bullet_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bullet_done); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_spawn_move();
    x_tank_l = 10'd288; y_tank_t = 10'd320; dir = 2'd0;
    fire_pulse();
    checks++; if (bullet_active !== 1'b0) begin errors++; $display("FAIL armed_not_visible: got %b expected 0", bullet_active); end
    tick();
    checks++; if (box !== {10'd302, 10'd305, 10'd316, 10'd319}) begin errors++;
      $display("FAIL spawn_up_box: got l=%0d r=%0d t=%0d b=%0d expected 302 305 316 319", x_bullet_l, x_bullet_r, y_bullet_t, y_bullet_b); end
    checks++; if (bullet_active !== 1'b1) begin errors++; $display("FAIL spawn_active: got %b expected 1", bullet_active); end
    repeat (3) tick();
    checks++; if (box !== {10'd302, 10'd305, 10'd304, 10'd307}) begin errors++;
      $display("FAIL move_up_box: got l=%0d r=%0d t=%0d b=%0d expected 302 305 304 307", x_bullet_l, x_bullet_r, y_bullet_t, y_bullet_b); end
  endtask

  task automatic test_dir_ignored();
    dir = 2'd3;
    tick();
    dir = 2'd0;
    checks++; if (box !== {10'd302, 10'd305, 10'd300, 10'd303}) begin errors++;
      $display("FAIL dir_ignored_box: got l=%0d r=%0d t=%0d b=%0d expected 302 305 300 303", x_bullet_l, x_bullet_r, y_bullet_t, y_bullet_b); end
  endtask

  task automatic test_hit();
    hit = 1'b1;
    step();
    hit = 1'b0;
    checks++; if (box !== {10'd302, 10'd305, 10'd300, 10'd303} || bullet_active !== 1'b1) begin errors++;
      $display("FAIL hit_no_tick: got t=%0d active=%b expected t=300 active=1", y_bullet_t, bullet_active); end
    fire_pulse();
    hit = 1'b1;
    tick();
    hit = 1'b0;
    checks++; if (bullet_done !== 1'b1) begin errors++; $display("FAIL hit_done: got %b expected 1", bullet_done); end
    checks++; if (box !== 40'd0 || bullet_active !== 1'b0) begin errors++;
      $display("FAIL hit_park: got l=%0d t=%0d active=%b expected 0 0 0", x_bullet_l, y_bullet_t, bullet_active); end
    step();
    checks++; if (bullet_done !== 1'b0) begin errors++; $display("FAIL hit_done_width: got %b expected 0", bullet_done); end
    tick();
    checks++; if (bullet_active !== 1'b0) begin errors++; $display("FAIL fly_edge_dropped: got active=%b expected 0", bullet_active); end
  endtask

  task automatic test_left_wall();
    do_reset();
    x_tank_l = 10'd40; y_tank_t = 10'd200; dir = 2'd2;
    fire_pulse();
    tick();
    checks++; if (box !== {10'd36, 10'd39, 10'd214, 10'd217}) begin errors++;
      $display("FAIL spawn_left_box: got l=%0d r=%0d t=%0d b=%0d expected 36 39 214 217", x_bullet_l, x_bullet_r, y_bullet_t, y_bullet_b); end
    tick();
    checks++; if (box !== {10'd32, 10'd35, 10'd214, 10'd217}) begin errors++;
      $display("FAIL at_wall_box: got l=%0d r=%0d t=%0d b=%0d expected 32 35 214 217", x_bullet_l, x_bullet_r, y_bullet_t, y_bullet_b); end
    tick();
    checks++; if (bullet_done !== 1'b1 || bullet_active !== 1'b0 || box !== 40'd0) begin errors++;
      $display("FAIL wall_retire: got done=%b active=%b l=%0d expected done=1 active=0 l=0", bullet_done, bullet_active, x_bullet_l); end
  endtask

`ifdef BULLET_COOLDOWN_EN
  task automatic test_cooldown();
    repeat (10) tick();
    fire_pulse();
    tick();
    checks++; if (bullet_active !== 1'b0) begin errors++; $display("FAIL cooldown_edge_dropped: got active=%b expected 0", bullet_active); end
    repeat (19) tick();
    fire_pulse();
    tick();
    checks++; if (bullet_active !== 1'b1) begin errors++; $display("FAIL cooldown_expired_fire: got active=%b expected 1", bullet_active); end
  endtask
`else
  task automatic test_back_to_back();
    fire = 1'b1;
    step();
    fire = 1'b0;
    checks++; if (bullet_done !== 1'b0) begin errors++; $display("FAIL b2b_done_width: got %b expected 0", bullet_done); end
    tick();
    checks++; if (bullet_active !== 1'b1 || box !== {10'd36, 10'd39, 10'd214, 10'd217}) begin errors++;
      $display("FAIL b2b_respawn: got active=%b l=%0d t=%0d expected active=1 l=36 t=214", bullet_active, x_bullet_l, y_bullet_t); end
  endtask
`endif

  task automatic test_blocked_spawn();
    do_reset();
    x_tank_l = 10'd288; y_tank_t = 10'd32; dir = 2'd0;
    fire_pulse();
    tick();
    checks++; if (bullet_done !== 1'b1 || bullet_active !== 1'b0 || box !== 40'd0) begin errors++;
      $display("FAIL blocked_retire: got done=%b active=%b t=%0d expected done=1 active=0 t=0", bullet_done, bullet_active, y_bullet_t); end
    step();
    checks++; if (bullet_done !== 1'b0 || bullet_active !== 1'b0) begin errors++;
      $display("FAIL blocked_after: got done=%b active=%b expected 0 0", bullet_done, bullet_active); end
  endtask

  task automatic test_edge_with_tick();
    do_reset();
    x_tank_l = 10'd288; y_tank_t = 10'd320; dir = 2'd1;
    fire = 1'b1; refresh_tick = 1'b1;
    step();
    fire = 1'b0; refresh_tick = 1'b0;
    step();
    checks++; if (bullet_active !== 1'b0) begin errors++; $display("FAIL edge_tick_armed_only: got active=%b expected 0", bullet_active); end
    tick();
    checks++; if (bullet_active !== 1'b1 || box !== {10'd302, 10'd305, 10'd352, 10'd355}) begin errors++;
      $display("FAIL spawn_down_box: got l=%0d r=%0d t=%0d b=%0d active=%b expected 302 305 352 355 1", x_bullet_l, x_bullet_r, y_bullet_t, y_bullet_b, bullet_active); end
  endtask

  task automatic test_async_reset();
    fire = 1'b1;
    step();
    tick();
    checks++; if (box !== {10'd302, 10'd305, 10'd356, 10'd359}) begin errors++;
      $display("FAIL move_down_box: got t=%0d b=%0d expected 356 359", y_bullet_t, y_bullet_b); end
    #5;
    reset = 1'b1;
    #1;
    checks++; if (box !== 40'd0 || bullet_active !== 1'b0 || bullet_done !== 1'b0) begin errors++;
      $display("FAIL async_reset_clear: got l=%0d t=%0d active=%b done=%b expected all 0", x_bullet_l, y_bullet_t, bullet_active, bullet_done); end
    step();
    step();
    #3;
    reset = 1'b0;
    step();
    tick();
    step();
    checks++; if (bullet_active !== 1'b0 || bullet_done !== 1'b0 || box !== 40'd0) begin errors++;
      $display("FAIL held_fire_no_spawn: got active=%b done=%b t=%0d expected 0 0 0", bullet_active, bullet_done, y_bullet_t); end
    fire = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_spawn_move();
    test_dir_ignored();
    test_hit();
    test_left_wall();
`ifdef BULLET_COOLDOWN_EN
    test_cooldown();
`else
    test_back_to_back();
`endif
    test_blocked_spawn();
    test_edge_with_tick();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
